// File: rtl/debounce_edge_gen.sv
// Debouncer with edge strobes for a downstream enabled flop, plus a saturating glitch counter.
// Define DEBOUNCE_SYNC_EN to put a 2-flop synchronizer in front of the sampler.
module debounce_edge_gen #(
    parameter int STABLE_CYCLES = 10,
    parameter int CNT_W         = 4,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_in,
    output logic                d_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic                en_pulse,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                d_reg;
    logic                rise_reg;
    logic                fall_reg;
    logic                en_reg;
    logic [GLITCH_W-1:0] glitch_reg;
    logic [GLITCH_W-1:0] glitch_next;
    logic                sample;

`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC_STAGES = 2;
    logic [SYNC_STAGES-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sample = sync_reg[SYNC_STAGES-1];
`else
    assign sample = raw_in;
`endif

    // Saturate at all-ones instead of wrapping back to zero.
    assign glitch_next = (&glitch_reg) ? glitch_reg : glitch_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= LOW;
            cnt_reg    <= '0;
            d_reg      <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            en_reg     <= 1'b0;
            glitch_reg <= '0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            en_reg   <= 1'b0;
            case (state_reg)
                LOW: begin
                    if (sample) begin
                        state_reg <= WAIT_HIGH;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sample) begin
                        state_reg  <= LOW;
                        cnt_reg    <= '0;
                        glitch_reg <= glitch_next;
                    end else if (cnt_reg == STABLE_LIM) begin
                        state_reg <= HIGH;
                        cnt_reg   <= '0;
                        d_reg     <= 1'b1;
                        rise_reg  <= 1'b1;
                        en_reg    <= 1'b1;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                    end
                end
                HIGH: begin
                    if (!sample) begin
                        state_reg <= WAIT_LOW;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sample) begin
                        state_reg  <= HIGH;
                        cnt_reg    <= '0;
                        glitch_reg <= glitch_next;
                    end else if (cnt_reg == STABLE_LIM) begin
                        state_reg <= LOW;
                        cnt_reg   <= '0;
                        d_reg     <= 1'b0;
                        fall_reg  <= 1'b1;
                        en_reg    <= 1'b1;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= LOW;
                    cnt_reg   <= '0;
                    d_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign d_out      = d_reg;
    assign rise_pulse = rise_reg;
    assign fall_pulse = fall_reg;
    assign en_pulse   = en_reg;
    assign glitch_cnt = glitch_reg;

endmodule
